// File: rtl/heartbeat_monitor.sv
// Heartbeat liveness checker: synchronises a toggling input, times the gap between edges, reports lock/fault.
// Latency: input change reaches state/period registers 3 clocks after it is first sampled.
// Backpressure: none; free-running monitor with level outputs and a saturating error counter.
module heartbeat_monitor #(
  parameter int T_NOM    = 15000000,
  parameter int T_TOL    = 1500000,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 26
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_hb,
  output logic             O_ok,
  output logic             O_fault,
  output logic [CNT_W-1:0] O_period,
  output logic [7:0]       O_err_cnt
);

  localparam logic [CNT_W-1:0] MAX_IV = CNT_W'(T_NOM + T_TOL);
  localparam logic [CNT_W-1:0] MIN_IV = CNT_W'(T_NOM - T_TOL);
  localparam int               GC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [GC_W-1:0]  LOCK_V = GC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKING,
    S_OK,
    S_FAULT
  } state_t;

  state_t            state;
  state_t            nxt_state;
  logic              sync1;
  logic              sync2;
  logic              hb_d;
  logic              hb_edge;
  logic [CNT_W-1:0]  cnt;
  logic              to_flag;
  logic              timeout;
  logic [CNT_W:0]    cnt_inc;
  logic [CNT_W-1:0]  interval;
  logic              good_int;
  logic [GC_W-1:0]   good_cnt;
  logic [GC_W-1:0]   nxt_good_cnt;
  logic              err_inc;

  // Two-flop synchroniser plus one history register for edge detection.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hb_d  <= 1'b0;
    end else begin
      sync1 <= I_hb;
      sync2 <= sync1;
      hb_d  <= sync2;
    end
  end

  // Both polarities of the heartbeat count as an edge.
  assign hb_edge = sync2 ^ hb_d;

  // Timeout fires once per gap: the flag blocks re-firing until the next edge.
  assign timeout = !hb_edge && !to_flag && (cnt == MAX_IV);

  // An edge landing exactly on the threshold is clamped to the maximum and treated as good.
  assign cnt_inc  = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign interval = (cnt_inc > {1'b0, MAX_IV}) ? MAX_IV : cnt_inc[CNT_W-1:0];
  assign good_int = (interval >= MIN_IV) && (interval <= MAX_IV);

  // Interval counter: restarts on every edge, saturates instead of wrapping.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      cnt <= '0;
    end else if (hb_edge) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Timeout flag set when the threshold fires, cleared by the next edge.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      to_flag <= 1'b0;
    end else if (hb_edge) begin
      to_flag <= 1'b0;
    end else if (timeout) begin
      to_flag <= 1'b1;
    end
  end

  // Publish the measured interval, skipping the first edge after idle (no valid start point).
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      O_period <= '0;
    end else if (hb_edge && (state != S_IDLE)) begin
      O_period <= interval;
    end
  end

  // State and good-interval count registers.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state    <= S_IDLE;
      good_cnt <= '0;
    end else begin
      state    <= nxt_state;
      good_cnt <= nxt_good_cnt;
    end
  end

  // Next-state logic; only a drop out of OK is counted as an error.
  always_comb begin
    nxt_state    = state;
    nxt_good_cnt = good_cnt;
    err_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (hb_edge) begin
          nxt_state    = S_LOCKING;
          nxt_good_cnt = '0;
        end else if (timeout) begin
          nxt_state = S_FAULT;
        end
      end
      S_LOCKING: begin
        if (hb_edge) begin
          if (good_int) begin
            if ((good_cnt + GC_W'(1)) == LOCK_V) begin
              nxt_state = S_OK;
            end
            nxt_good_cnt = good_cnt + GC_W'(1);
          end else begin
            nxt_good_cnt = '0;
          end
        end else if (timeout) begin
          nxt_state = S_FAULT;
        end
      end
      S_OK: begin
        if ((hb_edge && !good_int) || timeout) begin
          nxt_state = S_FAULT;
          err_inc   = 1'b1;
        end
      end
      S_FAULT: begin
        if (hb_edge) begin
          nxt_state    = S_LOCKING;
          nxt_good_cnt = '0;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // Saturating count of OK->FAULT transitions.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      O_err_cnt <= '0;
    end else if (err_inc && (O_err_cnt != 8'hFF)) begin
      O_err_cnt <= O_err_cnt + 8'd1;
    end
  end

  assign O_ok    = (state == S_OK);
  assign O_fault = (state == S_FAULT);

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with a small expected-value scoreboard.
// Latency: outputs sampled 1 time unit after the rising edge, 5 clocks after each heartbeat toggle.
// Backpressure: not applicable; stimulus is a timed heartbeat and reset.
module tb_heartbeat_monitor;

  localparam int T_NOM    = 20;
  localparam int T_TOL    = 2;
  localparam int LOCK_CNT = 3;
  localparam int CNT_W    = 8;

  typedef struct packed {
    logic       ok;
    logic       fault;
    logic [7:0] period;
    logic [7:0] err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             hb;
  logic             ok;
  logic             fault;
  logic [CNT_W-1:0] period;
  logic [7:0]       err_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  heartbeat_monitor #(
    .T_NOM    (T_NOM),
    .T_TOL    (T_TOL),
    .LOCK_CNT (LOCK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .I_clk     (clk),
    .I_reset   (rst),
    .I_hb      (hb),
    .O_ok      (ok),
    .O_fault   (fault),
    .O_period  (period),
    .O_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic e_ok, input logic e_fault,
                            input logic [7:0] e_period, input logic [7:0] e_err);
    exp_t e;
    e.ok     = e_ok;
    e.fault  = e_fault;
    e.period = e_period;
    e.err    = e_err;
    exp_q.push_back(e);
  endtask

  task automatic check_field(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_field({tag, ".ok"},     {7'b0, ok},    {7'b0, e.ok});
      check_field({tag, ".fault"},  {7'b0, fault}, {7'b0, e.fault});
      check_field({tag, ".period"}, period,        e.period);
      check_field({tag, ".err"},    err_cnt,       e.err);
    end
  endtask

  // Wait until 'gap' clocks after the previous toggle (which was 5 clocks ago), toggle,
  // queue the expected outputs and compare them 5 clocks later.
  task automatic step(input string tag, input int gap, input logic e_ok, input logic e_fault,
                      input logic [7:0] e_period, input logic [7:0] e_err);
    tick(gap - 5);
    hb = ~hb;
    expect_out(e_ok, e_fault, e_period, e_err);
    tick(5);
    pop_compare(tag);
  endtask

  task automatic toggle_wait(input int n);
    hb = ~hb;
    tick(n);
  endtask

  initial begin
    rst = 1'b1;
    hb  = 1'b0;
    tick(3);

    // 1: reset state, then lock on nominal 20-clock toggles
    expect_out(1'b0, 1'b0, 8'd0, 8'd0);
    pop_compare("reset_state");
    rst = 1'b0;
    step("t1_edge1", 5,  1'b0, 1'b0, 8'd0,  8'd0);
    step("t1_edge2", 20, 1'b0, 1'b0, 8'd20, 8'd0);
    step("t1_edge3", 20, 1'b0, 1'b0, 8'd20, 8'd0);
    step("t1_edge4", 20, 1'b1, 1'b0, 8'd20, 8'd0);

    // 2: tolerance edges; 23 lands on the threshold and is clamped to 22
    step("t2_min18", 18, 1'b1, 1'b0, 8'd18, 8'd0);
    step("t2_max22", 22, 1'b1, 1'b0, 8'd22, 8'd0);
    step("t2_tie23", 23, 1'b1, 1'b0, 8'd22, 8'd0);

    // 3: one short interval faults, then relock after three good intervals
    step("t3_short17", 17, 1'b0, 1'b1, 8'd17, 8'd1);
    step("t3_refresh", 20, 1'b0, 1'b0, 8'd20, 8'd1);
    step("t3_good1",   20, 1'b0, 1'b0, 8'd20, 8'd1);
    step("t3_good2",   20, 1'b0, 1'b0, 8'd20, 8'd1);
    step("t3_good3",   20, 1'b1, 1'b0, 8'd20, 8'd1);

    // 4: heartbeat stops; a single timeout fault, no repeated count
    expect_out(1'b1, 1'b0, 8'd20, 8'd1);
    tick(19);
    pop_compare("t4_before_timeout");
    expect_out(1'b0, 1'b1, 8'd20, 8'd2);
    tick(6);
    pop_compare("t4_timeout");
    expect_out(1'b0, 1'b1, 8'd20, 8'd2);
    tick(300);
    pop_compare("t4_no_repeat");

    // 5: static input from reset faults from IDLE after 23 clocks without counting an error
    hb  = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_out(1'b0, 1'b0, 8'd0, 8'd0);
    tick(22);
    pop_compare("t5_clk22");
    expect_out(1'b0, 1'b1, 8'd0, 8'd0);
    tick(1);
    pop_compare("t5_clk23");

    // 6: 256 forced OK->FAULT drops saturate the error counter
    for (int i = 0; i < 256; i++) begin
      toggle_wait(20);
      toggle_wait(20);
      toggle_wait(20);
      toggle_wait(10);
      toggle_wait(20);
    end
    expect_out(1'b0, 1'b1, 8'd10, 8'd255);
    pop_compare("t6_saturated");
    step("t6_refresh", 5,  1'b0, 1'b0, 8'd20, 8'd255);
    step("t6_good1",   20, 1'b0, 1'b0, 8'd20, 8'd255);
    step("t6_good2",   20, 1'b0, 1'b0, 8'd20, 8'd255);
    step("t6_good3",   20, 1'b1, 1'b0, 8'd20, 8'd255);

    // asynchronous reset mid-cycle clears all outputs immediately
    tick(7);
    #2;
    rst = 1'b1;
    expect_out(1'b0, 1'b0, 8'd0, 8'd0);
    #1;
    pop_compare("t6_async_reset");
    tick(2);
    rst = 1'b0;
    expect_out(1'b0, 1'b0, 8'd0, 8'd0);
    tick(1);
    pop_compare("t6_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
